delay_line8: RTL and testbench



---
 rtl/delay_line8_if.sv | 10 +
 rtl/delay_line8.sv | 74 +++++++
 tb/tb_delay_line8.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/delay_line8_if.sv
// Sample data path of the 8-cycle delay line: x goes in, y comes out eight edges later.
interface delay_line8_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    modport master (output x, input  y);
    modport slave  (input  x, output y);
endinterface

// File: rtl/delay_line8.sv
// Fixed 8-cycle delay of a WIDTH-bit sample, with all 8*WIDTH flops stitched into 5 scan chains.
module delay_line8 #(
    parameter int WIDTH = 24
) (
    input  logic          clk,
    input  logic          reset,
    delay_line8_if.slave  data,
    input  logic          scan_enable,
    input  logic          scan_in0,
    input  logic          scan_in1,
    input  logic          scan_in2,
    input  logic          scan_in3,
    input  logic          scan_in4,
    output logic          scan_out0,
    output logic          scan_out1,
    output logic          scan_out2,
    output logic          scan_out3,
    output logic          scan_out4
);
    localparam int NUM_STAGES = 8;
    localparam int NUM_FLOPS  = NUM_STAGES * WIDTH;
    localparam int NUM_CHAINS = 5;

    // Flat flop index j = stage*WIDTH + bit, so stage s occupies bits [s*WIDTH +: WIDTH].
    logic [NUM_FLOPS-1:0]  flops_reg;
    logic [NUM_FLOPS-1:0]  flops_next;
    logic [NUM_CHAINS-1:0] scan_in_vec;
    logic [NUM_CHAINS-1:0] scan_out_vec;

    assign scan_in_vec = {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOPS; gi++) begin : g_flop
            logic scan_d;
            logic func_d;

            // Chain c holds flops j = c, c+5, c+10, ...; its predecessor is always j-5.
            if (gi < NUM_CHAINS) begin : g_chain_head
                assign scan_d = scan_in_vec[gi];
            end else begin : g_chain_link
                assign scan_d = flops_reg[gi-NUM_CHAINS];
            end

            if (gi < WIDTH) begin : g_first_stage
                assign func_d = data.x[gi];
            end else begin : g_later_stage
                assign func_d = flops_reg[gi-WIDTH];
            end

            assign flops_next[gi] = scan_enable ? scan_d : func_d;
        end

        for (gi = 0; gi < NUM_CHAINS; gi++) begin : g_scan_out
            localparam int LAST_J = NUM_FLOPS - 1 - ((NUM_FLOPS - 1 - gi) % NUM_CHAINS);
            assign scan_out_vec[gi] = flops_reg[LAST_J];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            flops_reg <= '0;
        end else begin
            flops_reg <= flops_next;
        end
    end

    assign data.y    = flops_reg[NUM_FLOPS-1 -: WIDTH];
    assign scan_out0 = scan_out_vec[0];
    assign scan_out1 = scan_out_vec[1];
    assign scan_out2 = scan_out_vec[2];
    assign scan_out3 = scan_out_vec[3];
    assign scan_out4 = scan_out_vec[4];
endmodule

// File: tb/tb_delay_line8.sv
// Bench for delay_line8: vector table, hand-written corner sequences, then random traffic vs. a reference model.
module tb_delay_line8;
    localparam int W = 24;
    localparam int N = 8 * W;

    logic       test_clk = 1'b0;
    logic       reset;
    logic       scan_enable;
    logic [4:0] scan_in;
    logic [4:0] scan_out;

    int total = 0;
    int bad   = 0;

    always #5 test_clk = ~test_clk;

    delay_line8_if #(.WIDTH(W)) bus ();

    delay_line8 #(.WIDTH(W)) dut (
        .clk         (test_clk),
        .reset       (reset),
        .data        (bus),
        .scan_enable (scan_enable),
        .scan_in0    (scan_in[0]),
        .scan_in1    (scan_in[1]),
        .scan_in2    (scan_in[2]),
        .scan_in3    (scan_in[3]),
        .scan_in4    (scan_in[4]),
        .scan_out0   (scan_out[0]),
        .scan_out1   (scan_out[1]),
        .scan_out2   (scan_out[2]),
        .scan_out3   (scan_out[3]),
        .scan_out4   (scan_out[4])
    );

    // Reference model: queue of the 8 held words, index 0 is the newest sample.
    logic [W-1:0] mq[$];

    function automatic logic mbit(int j);
        logic [W-1:0] w;
        w = mq[j / W];
        return w[j % W];
    endfunction

    task automatic set_mbit(int j, logic v);
        logic [W-1:0] w;
        w = mq[j / W];
        w[j % W] = v;
        mq[j / W] = w;
    endtask

    function automatic int chain_last(int c);
        int last;
        last = c;
        for (int j = c; j < N; j += 5) last = j;
        return last;
    endfunction

    task automatic model_edge();
        if (reset) begin
            mq.delete();
            for (int s = 0; s < 8; s++) mq.push_back('0);
        end else if (!scan_enable) begin
            mq.push_front(bus.x);
            void'(mq.pop_back());
        end else begin
            for (int c = 0; c < 5; c++) begin
                int lst[$];
                for (int j = c; j < N; j += 5) lst.push_back(j);
                for (int k = lst.size() - 1; k > 0; k--) set_mbit(lst[k], mbit(lst[k-1]));
                set_mbit(lst[0], scan_in[c]);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge test_clk);
        #1;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(string name);
        logic [4:0] exp_so;
        for (int c = 0; c < 5; c++) exp_so[c] = mbit(chain_last(c));
        check({name, "_y"}, 64'(bus.y), 64'(mq[7]));
        check({name, "_scan_out"}, 64'(scan_out), 64'(exp_so));
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] x;
        logic [W-1:0] exp_y;
        logic [4:0]   exp_so;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t         v;
        logic [W-1:0] xs[$];
        logic [W-1:0] pat[8];

        reset       = 1'b1;
        scan_enable = 1'b0;
        scan_in     = '0;
        bus.x       = 24'hFFFFFF;
        for (int s = 0; s < 8; s++) mq.push_back('0);

        // Two reset rows with all-ones input must still read back zero.
        for (int i = 0; i < 2; i++) begin
            v.rst = 1'b1; v.x = 24'hFFFFFF; v.exp_y = '0; v.exp_so = '0;
            vecs.push_back(v);
        end
        // Functional stream: ramp 1..20, full-width patterns, then flush.
        for (int i = 1; i <= 20; i++) xs.push_back(W'(i));
        pat = '{24'hAAAAAA, 24'h555555, 24'hAAAAAA, 24'h555555,
                24'h800000, 24'h7FFFFF, 24'hAAAAAA, 24'h555555};
        for (int i = 0; i < 8; i++) xs.push_back(pat[i]);
        for (int i = 0; i < 8; i++) xs.push_back('0);
        // After the edge that samples row i, y shows the value sampled 7 edges earlier.
        for (int i = 0; i < xs.size(); i++) begin
            v.rst = 1'b0; v.x = xs[i];
            v.exp_y = (i >= 7) ? xs[i-7] : '0;
            v.exp_so = 'x;
            vecs.push_back(v);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            bus.x = vecs[i].x;
            step();
            $display("vec %0d: rst=%0b x=%06h y=%06h exp=%06h", i, reset, bus.x, bus.y, vecs[i].exp_y);
            check("table_y", 64'(bus.y), 64'(vecs[i].exp_y));
            if (vecs[i].rst) check("table_scan_out", 64'(scan_out), 64'(vecs[i].exp_so));
        end

        // Mid-stream reset: steady 123456, one reset cycle, then refill.
        reset = 1'b0;
        bus.x = 24'h123456;
        for (int i = 0; i < 20; i++) step();
        check("steady_y", 64'(bus.y), 64'h123456);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            $display("midreset k=%0d y=%06h", k, bus.y);
            check("midreset_zero", 64'(bus.y), 64'h0);
            if (k < 7) step();
        end
        step();
        $display("midreset refill y=%06h", bus.y);
        check("midreset_refill", 64'(bus.y), 64'h123456);

        // Scan: one 1 injected into chain 0 must reach scan_out0 on edge 39.
        reset = 1'b1;
        step();
        reset       = 1'b0;
        scan_enable = 1'b1;
        scan_in     = 5'b00001;
        for (int k = 1; k <= 39; k++) begin
            step();
            scan_in = '0;
            check("scan_chain0", 64'(scan_out[0]), (k == 39) ? 64'h1 : 64'h0);
            check("scan_others", 64'(scan_out[4:1]), 64'h0);
        end
        $display("scan injected bit reached scan_out0 state=%05b", scan_out);
        check_model("scan_end");

        // Functional shifting resumes from the scanned-in state.
        scan_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.x = W'($urandom);
            step();
            $display("resume %0d: x=%06h y=%06h", i, bus.x, bus.y);
            check_model("resume");
        end

        // Random mix of reset, scan and functional cycles.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            scan_enable = ($urandom_range(0, 3) == 0);
            scan_in     = 5'($urandom);
            bus.x       = W'($urandom);
            step();
            $display("rand %0d: rst=%0b se=%0b si=%05b x=%06h y=%06h so=%05b",
                     i, reset, scan_enable, scan_in, bus.x, bus.y, scan_out);
            check_model("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
